// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between the decode stage and the register scoreboard.
//   master : decode side; drives issue, source, writeback and flush signals.
//   slave  : scoreboard side; returns stall, issue_ok, pending and stall_cycles.
interface reg_scoreboard_if;
  logic        issue_valid;
  logic        issue_wr;
  logic [2:0]  issue_wrsel;
  logic        src1_use;
  logic [2:0]  src1_sel;
  logic        src2_use;
  logic [2:0]  src2_sel;
  logic        wb_write;
  logic [2:0]  wb_sel;
  logic        flush;
  logic        stall;
  logic        issue_ok;
  logic [7:0]  pending;
  logic [15:0] stall_cycles;

  modport master (
    output issue_valid, issue_wr, issue_wrsel,
    output src1_use, src1_sel, src2_use, src2_sel,
    output wb_write, wb_sel, flush,
    input  stall, issue_ok, pending, stall_cycles
  );

  modport slave (
    input  issue_valid, issue_wr, issue_wrsel,
    input  src1_use, src1_sel, src2_use, src2_sel,
    input  wb_write, wb_sel, flush,
    output stall, issue_ok, pending, stall_cycles
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per architectural register and
// stalls issue on read-after-write or counter-capacity hazards.
//   clk, rst         : clock and asynchronous active-low reset
//   bus (slave)      : issue/source/writeback/flush in; stall, issue_ok
//                      (combinational), pending, stall_cycles (registered) out
module reg_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_scoreboard_if.slave bus
);

  localparam int unsigned NREG = 8;
  localparam int unsigned SC_W = 16;
  localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};
  localparam logic [SC_W-1:0]  SC_MAX = {SC_W{1'b1}};

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_d;
  logic [SC_W-1:0]  stall_cycles_q;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  dec;
  logic             haz;
  logic             full;
  logic             stall;
  logic             issue_ok;

  // Hazard detection; no writeback bypass since the regfile returns the old value.
  always_comb begin
    haz      = (bus.src1_use && (cnt_q[bus.src1_sel] != '0)) ||
               (bus.src2_use && (cnt_q[bus.src2_sel] != '0));
    full     = bus.issue_wr && (cnt_q[bus.issue_wrsel] == MAXC);
    stall    = bus.issue_valid && !bus.flush && (haz || full);
    issue_ok = bus.issue_valid && !stall;
  end

  // Per-register increment/decrement strobes; writeback to an idle register is dropped.
  always_comb begin
    inc = '0;
    dec = '0;
    for (int i = 0; i < NREG; i++) begin
      inc[i] = issue_ok && bus.issue_wr && !bus.flush && (bus.issue_wrsel == 3'(i));
      dec[i] = bus.wb_write && (bus.wb_sel == 3'(i)) && (cnt_q[i] != '0);
    end
  end

  // Next counter values; flush overrides everything.
  always_comb begin
    pending_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (bus.flush)
        cnt_d[i] = '0;
      else if (inc[i] && !dec[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (dec[i] && !inc[i])
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      pending_d[i] = (cnt_d[i] != '0);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      pending_q      <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      pending_q <= pending_d;
      if (stall && (stall_cycles_q != SC_MAX))
        stall_cycles_q <= stall_cycles_q + SC_W'(1);
    end
  end

  assign bus.stall        = stall;
  assign bus.issue_ok     = issue_ok;
  assign bus.pending      = pending_q;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  typedef struct {
    logic [7:0]  pending;
    logic [15:0] stall_cycles;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  int   cnt_m [8];
  int   sc_m;
  exp_t exp_q [$];
  logic last_stall;
  logic last_ok;

  reg_scoreboard_if bus ();

  reg_scoreboard #(.CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_pending();
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) p[i] = (cnt_m[i] != 0);
    return p;
  endfunction

  task automatic idle_inputs();
    bus.issue_valid = 0; bus.issue_wr = 0; bus.issue_wrsel = 0;
    bus.src1_use = 0; bus.src1_sel = 0; bus.src2_use = 0; bus.src2_sel = 0;
    bus.wb_write = 0; bus.wb_sel = 0; bus.flush = 0;
  endtask

  // One clock of stimulus: check combinational outputs against the model,
  // push the expected registered outputs, then pop and compare after the edge.
  task automatic step(input string tag, input logic iv, input logic wr, input int wrsel,
                      input logic s1u, input int s1s, input logic s2u, input int s2s,
                      input logic wbw, input int wbs, input logic fl);
    logic haz, full, stall_e, ok_e;
    exp_t e, got;
    @(negedge clk);
    bus.issue_valid = iv; bus.issue_wr = wr; bus.issue_wrsel = 3'(wrsel);
    bus.src1_use = s1u; bus.src1_sel = 3'(s1s);
    bus.src2_use = s2u; bus.src2_sel = 3'(s2s);
    bus.wb_write = wbw; bus.wb_sel = 3'(wbs); bus.flush = fl;
    #1;
    haz     = (s1u && cnt_m[s1s] != 0) || (s2u && cnt_m[s2s] != 0);
    full    = wr && (cnt_m[wrsel] == 3);
    stall_e = iv && !fl && (haz || full);
    ok_e    = iv && !stall_e;
    last_stall = bus.stall;
    last_ok    = bus.issue_ok;
    chk({tag, "_stall"}, 32'(bus.stall), 32'(stall_e));
    chk({tag, "_ok"}, 32'(bus.issue_ok), 32'(ok_e));
    if (fl) begin
      for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic inc_m, dec_m;
        inc_m = ok_e && wr && (wrsel == i);
        dec_m = wbw && (wbs == i) && (cnt_m[i] != 0);
        if (inc_m && !dec_m) cnt_m[i]++;
        else if (dec_m && !inc_m) cnt_m[i]--;
      end
    end
    if (stall_e && sc_m != 16'hFFFF) sc_m++;
    e.pending = model_pending();
    e.stall_cycles = 16'(sc_m);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      got = exp_q.pop_front();
      chk({tag, "_pending"}, 32'(bus.pending), 32'(got.pending));
      chk({tag, "_stall_cycles"}, 32'(bus.stall_cycles), 32'(got.stall_cycles));
    end
  endtask

  task automatic issue_w(input string tag, input int r);
    step(tag, 1, 1, r, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wb(input string tag, input int r);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 1, r, 0);
  endtask

  int sc_before;

  initial begin
    checks = 0;
    errors = 0;
    sc_m = 0;
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    idle_inputs();
    rst = 1'b0;
    // Reset state; a would-be hazard read still cannot stall with empty counters.
    bus.issue_valid = 1; bus.issue_wr = 1; bus.src1_use = 1; bus.src1_sel = 3;
    #12;
    chk("rst_pending", 32'(bus.pending), 32'h00);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_issue_ok", 32'(bus.issue_ok), 32'h1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;

    // Basic RAW hazard on R3.
    issue_w("raw_issue", 3);
    chk("raw_pend08", 32'(bus.pending), 32'h08);
    step("raw_hold", 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("raw_stall1", 32'(last_stall), 32'h1);
    chk("raw_ok0", 32'(last_ok), 32'h0);
    step("raw_wb", 1, 0, 0, 1, 3, 0, 0, 1, 3, 0);
    chk("raw_wb_nobypass", 32'(last_stall), 32'h1);
    step("raw_go", 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    chk("raw_stall0", 32'(last_stall), 32'h0);
    chk("raw_pend00", 32'(bus.pending), 32'h00);

    // Same-cycle writeback on source 2 is not bypassed.
    issue_w("nb_issue", 5);
    step("nb_wb", 1, 0, 0, 0, 0, 1, 5, 1, 5, 0);
    chk("nb_stall1", 32'(last_stall), 32'h1);
    step("nb_after", 1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    chk("nb_stall0", 32'(last_stall), 32'h0);

    // Capacity limit on R1.
    issue_w("cap_i1", 1);
    issue_w("cap_i2", 1);
    issue_w("cap_i3", 1);
    issue_w("cap_i4", 1);
    chk("cap_full_stall", 32'(last_stall), 32'h1);
    wb("cap_wb", 1);
    issue_w("cap_i4b", 1);
    chk("cap_i4b_ok", 32'(last_ok), 32'h1);
    issue_w("cap_i5", 1);
    chk("cap_still_full", 32'(last_stall), 32'h1);
    wb("cap_d1", 1);
    wb("cap_d2", 1);
    wb("cap_d3", 1);
    chk("cap_drained", 32'(bus.pending), 32'h00);

    // Simultaneous issue and writeback on R2, then spurious writeback on R6.
    issue_w("sim_issue", 2);
    step("sim_both", 1, 1, 2, 0, 0, 0, 0, 1, 2, 0);
    chk("sim_pend2", 32'(bus.pending[2]), 32'h1);
    wb("sim_wb", 2);
    chk("sim_cnt2_was1", 32'(bus.pending), 32'h00);
    wb("spur_wb6", 6);
    issue_w("spur_i1", 6);
    issue_w("spur_i2", 6);
    issue_w("spur_i3", 6);
    chk("spur_no_underflow", 32'(last_ok), 32'h1);

    // Flush with simultaneous issue.
    step("fl_clr", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) issue_w($sformatf("fl_fill%0d", i), i);
    chk("fl_pendFF", 32'(bus.pending), 32'hFF);
    step("fl_flush", 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("fl_pend00", 32'(bus.pending), 32'h00);
    chk("fl_r0_notcounted", 32'(last_ok), 32'h1);

    // Four stalled cycles, then asynchronous reset mid-cycle.
    issue_w("st_issue", 4);
    sc_before = 32'(bus.stall_cycles);
    for (int i = 0; i < 4; i++) step($sformatf("st_hold%0d", i), 1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    chk("st_delta4", 32'(bus.stall_cycles) - 32'(sc_before), 32'd4);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_stall_cycles", 32'(bus.stall_cycles), 32'h0);
    chk("ar_pending", 32'(bus.pending), 32'h00);
    chk("ar_stall", 32'(bus.stall), 32'h0);
    for (int i = 0; i < 8; i++) cnt_m[i] = 0;
    sc_m = 0;
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    step("post_rst_src4", 1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    issue_w("post_rst_i7", 7);
    chk("post_rst_pend80", 32'(bus.pending), 32'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter: CNT_W, default 2, width of each per-register in-flight counter; the per-register maximum is MAXC = 2^CNT_W - 1.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 issue_valid  input  1  the decode stage has an instruction attempting to issue this cycle.
REQ-005 issue_wr  input  1  the issuing instruction writes a register.
REQ-006 issue_wrsel  input  3  destination register index of the issuing instruction.
REQ-007 src1_use, src2_use  input  1 each  the issuing instruction reads source 1 / source 2.
REQ-008 src1_sel, src2_sel  input  3 each  source register indices; these are the same values driven to the register file read selects.
REQ-009 wb_write, wb_sel  input  1, 3  writeback completion; these are the same values driven to the register file write and write-select inputs.
REQ-010 flush  input  1  squash all in-flight instructions.
REQ-011 stall  output  1  combinational; the issuing instruction must hold in decode.
REQ-012 issue_ok  output  1  combinational; equals issue_valid & ~stall.
REQ-013 pending  output  8  registered; bit i = (cnt[i] != 0).
REQ-014 stall_cycles  output  16  registered, saturating count of stalled cycles.

Function
REQ-015 State: eight counters cnt[0..7], each CNT_W bits wide, plus stall_cycles.
REQ-016 Data hazard (RAW): haz = (src1_use & cnt[src1_sel]!=0) | (src2_use & cnt[src2_sel]!=0).
- There is no same-cycle writeback bypass.
- A hazard is asserted even when wb_write targets that register in the same cycle, because the register file returns the old value.
REQ-017 Capacity hazard: full = issue_wr & (cnt[issue_wrsel]==MAXC).
REQ-018 stall = issue_valid & ~flush & (haz | full).
- When issue_valid=0 or flush=1, stall=0.
REQ-019 inc[i] = issue_ok & issue_wr & ~flush & (issue_wrsel==i).
REQ-020 dec[i] = wb_write & (wb_sel==i) & (cnt[i]!=0).
- A writeback to a register whose counter is 0 is ignored; no underflow.
REQ-021 Counter update, next cycle:
- inc & ~dec: cnt+1.
- dec & ~inc: cnt-1.
- inc & dec together: unchanged.
- neither: unchanged.
REQ-022 flush=1 clears every counter to 0 on the next edge, overriding inc and dec in the same cycle.
REQ-023 The counter of a register other than issue_wrsel/wb_sel never changes.
REQ-024 Counters never exceed MAXC; the capacity hazard guarantees this, and no wrap-around is permitted.
REQ-025 stall_cycles increments by 1 on each cycle where stall=1, and holds at 16'hFFFF once it saturates.
REQ-026 Latency: an issue is visible in pending and in hazard checks on the cycle after issue_ok.
REQ-027 Latency: a writeback clears a hazard on the cycle after wb_write.
REQ-028 issue_ok is purely combinational from the current state and inputs; it contains no internal registers.

Reset
REQ-029 While rst=0, asynchronously:
- all cnt = 0;
- pending = 8'h00;
- stall_cycles = 16'h0000.
REQ-030 While rst=0, stall and issue_ok follow REQ-018 and REQ-012 with all counters zero; therefore stall=0.
REQ-031 Reset asserted mid-operation discards all in-flight state.
- On the first edge after rst returns to 1, the block behaves as after a cold reset.
REQ-032 Flush and reset are independent; flush does not reset stall_cycles.

Verification
REQ-033 Basic RAW hazard:
- Issue a write to R3 (issue_valid=1, issue_wr=1, issue_wrsel=3).
- Next cycle, issue with src1_use=1, src1_sel=3 -> stall=1, issue_ok=0, pending=8'h08.
- Apply wb_write=1, wb_sel=3 -> stall=0 on the following cycle, pending=8'h00.
REQ-034 Same-cycle writeback, no bypass:
- With cnt[5]=1, apply src2_sel=5 (src2_use=1) and wb_write/wb_sel=5 together -> stall=1 that cycle.
- Next cycle -> stall=0.
REQ-035 Capacity limit (CNT_W=2):
- Issue three writes to R1 with no writeback -> cnt[1]=3.
- A fourth write to R1 -> stall=1.
- After one writeback to R1 -> the fourth issues; cnt[1] stays 3.
REQ-036 Simultaneous issue and writeback:
- With cnt[2]=1, issue a write to R2 and apply wb to R2 in the same cycle -> cnt[2]=1, pending[2]=1.
- Spurious wb to R6 with cnt[6]=0 -> cnt[6] stays 0.
REQ-037 Flush and reset:
- Set pending=8'hFF, then apply flush=1 with a simultaneous issue to R0 -> pending=8'h00; the R0 issue is not counted.
- Hold a stall for 4 cycles -> stall_cycles=4.
- Drive rst=0 asynchronously mid-cycle -> stall_cycles=0 and pending=0 immediately.
